wb_regfile_stage: RTL

- Write-back end of the dual-issue pipeline: latches the a/b instruction pair leaving MEM and commits results into the architectural register file.
- Owns the 32x32 register file with 2 write ports and 4 combinational read ports consumed by the read-operands stage.
- Publishes WB-stage forwarding signals (valid/forwardable/dest/result per slot), a precise-exception report and a retired-instruction counter.

---
 rtl/wb_regfile_stage_pkg.sv | 25 ++
 rtl/wb_regfile_stage_regfile_2w4r.sv | 54 +++++
 rtl/wb_regfile_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/wb_regfile_stage_pkg.sv
// rtl/wb_regfile_stage_pkg.sv - shared types and constants for the write-back stage
package wb_regfile_stage_pkg;

    localparam int NUM_GPR = 32;
    localparam int GPR_AW  = 5;

    typedef enum logic [5:0] {
        EXC_NONE = 6'h00,
        EXC_INT  = 6'h01,
        EXC_PIL  = 6'h02,
        EXC_PIS  = 6'h03,
        EXC_PIF  = 6'h04,
        EXC_PME  = 6'h05,
        EXC_PPI  = 6'h07,
        EXC_ADEF = 6'h08,
        EXC_ADEM = 6'h09,
        EXC_ALE  = 6'h0a,
        EXC_SYS  = 6'h0b,
        EXC_BRK  = 6'h0c,
        EXC_INE  = 6'h0d,
        EXC_IPE  = 6'h0e,
        EXC_FPD  = 6'h0f
    } exception_t;

endpackage

// File: rtl/wb_regfile_stage_regfile_2w4r.sv
// rtl/wb_regfile_stage_regfile_2w4r.sv - 32-entry GPR array, two write ports, four read ports
module regfile_2w4r
    import wb_regfile_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit RESET_REGS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_a,
    input  logic [GPR_AW-1:0]     waddr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  we_b,
    input  logic [GPR_AW-1:0]     waddr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic [GPR_AW-1:0]     r1_addr,
    input  logic [GPR_AW-1:0]     r2_addr,
    input  logic [GPR_AW-1:0]     r3_addr,
    input  logic [GPR_AW-1:0]     r4_addr,
    output logic [DATA_WIDTH-1:0] r1_data,
    output logic [DATA_WIDTH-1:0] r2_data,
    output logic [DATA_WIDTH-1:0] r3_data,
    output logic [DATA_WIDTH-1:0] r4_data
);

    logic [DATA_WIDTH-1:0] regs [NUM_GPR];

    // Array update: slot b is younger, so its write is applied last and wins a same-dest collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (RESET_REGS) begin
                for (int i = 0; i < NUM_GPR; i++) begin
                    regs[i] <= '0;
                end
            end
        end else begin
            if (we_a && (waddr_a != '0)) begin
                regs[waddr_a] <= wdata_a;
            end
            if (we_b && (waddr_b != '0)) begin
                regs[waddr_b] <= wdata_b;
            end
        end
    end

    // Reads come straight from the array; the WB-cycle value is covered by forwarding, r0 is hardwired
    always_comb begin
        r1_data = (r1_addr == '0) ? '0 : regs[r1_addr];
        r2_data = (r2_addr == '0) ? '0 : regs[r2_addr];
        r3_data = (r3_addr == '0) ? '0 : regs[r3_addr];
        r4_data = (r4_addr == '0) ? '0 : regs[r4_addr];
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// rtl/wb_regfile_stage.sv - dual-issue write-back stage with register file, exception report and retire counter
module wb_regfile_stage
    import wb_regfile_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit RESET_REGS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  mem_stall,
    input  logic                  mem_a_valid,
    input  logic [31:0]           mem_a_pc,
    input  logic                  mem_a_have_exception,
    input  exception_t            mem_a_exception_type,
    input  logic [GPR_AW-1:0]     mem_a_dest,
    input  logic [DATA_WIDTH-1:0] mem_a_result,
    input  logic                  mem_b_valid,
    input  logic [31:0]           mem_b_pc,
    input  logic                  mem_b_have_exception,
    input  exception_t            mem_b_exception_type,
    input  logic [GPR_AW-1:0]     mem_b_dest,
    input  logic [DATA_WIDTH-1:0] mem_b_result,
    output logic                  wb_a_valid,
    output logic                  wb_a_forwardable,
    output logic [GPR_AW-1:0]     wb_a_dest,
    output logic [DATA_WIDTH-1:0] wb_a_result,
    output logic                  wb_b_valid,
    output logic                  wb_b_forwardable,
    output logic [GPR_AW-1:0]     wb_b_dest,
    output logic [DATA_WIDTH-1:0] wb_b_result,
    output logic                  wb_exc_valid,
    output exception_t            wb_exc_type,
    output logic [31:0]           wb_exc_pc,
    input  logic [GPR_AW-1:0]     r1_addr,
    input  logic [GPR_AW-1:0]     r2_addr,
    input  logic [GPR_AW-1:0]     r3_addr,
    input  logic [GPR_AW-1:0]     r4_addr,
    output logic [DATA_WIDTH-1:0] r1_data,
    output logic [DATA_WIDTH-1:0] r2_data,
    output logic [DATA_WIDTH-1:0] r3_data,
    output logic [DATA_WIDTH-1:0] r4_data,
    output logic [31:0]           retired_count
);

    logic                  a_valid_q, b_valid_q;
    logic [31:0]           a_pc_q, b_pc_q;
    logic                  a_exc_q, b_exc_q;
    exception_t            a_etype_q, b_etype_q;
    logic [GPR_AW-1:0]     a_dest_q, b_dest_q;
    logic [DATA_WIDTH-1:0] a_res_q, b_res_q;
    logic [31:0]           retired_q;

    logic                  a_commit, b_commit;
    logic [1:0]            n_commit;

    // MEM->WB pipeline register; flush takes precedence over stall, both simply empty the stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_pc_q    <= '0;
            b_pc_q    <= '0;
            a_exc_q   <= 1'b0;
            b_exc_q   <= 1'b0;
            a_etype_q <= EXC_NONE;
            b_etype_q <= EXC_NONE;
            a_dest_q  <= '0;
            b_dest_q  <= '0;
            a_res_q   <= '0;
            b_res_q   <= '0;
        end else if (flush || mem_stall) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_valid_q <= mem_a_valid;
            b_valid_q <= mem_b_valid;
            a_pc_q    <= mem_a_pc;
            b_pc_q    <= mem_b_pc;
            a_exc_q   <= mem_a_have_exception;
            b_exc_q   <= mem_b_have_exception;
            a_etype_q <= mem_a_exception_type;
            b_etype_q <= mem_b_exception_type;
            a_dest_q  <= mem_a_dest;
            b_dest_q  <= mem_b_dest;
            a_res_q   <= mem_a_result;
            b_res_q   <= mem_b_result;
        end
    end

    // Slot b is squashed when the older slot a faults; forwardable results are exactly the GPR writes
    always_comb begin
        wb_a_valid       = a_valid_q;
        wb_b_valid       = b_valid_q && !(a_valid_q && a_exc_q);
        wb_a_forwardable = wb_a_valid && !a_exc_q && (a_dest_q != '0);
        wb_b_forwardable = wb_b_valid && !b_exc_q && (b_dest_q != '0);
        wb_a_dest        = a_dest_q;
        wb_b_dest        = b_dest_q;
        wb_a_result      = a_res_q;
        wb_b_result      = b_res_q;
        a_commit         = wb_a_valid && !a_exc_q;
        b_commit         = wb_b_valid && !b_exc_q;
        n_commit         = {1'b0, a_commit} + {1'b0, b_commit};
    end

    // Precise exception pick: the oldest faulting slot that is still alive reports
    always_comb begin
        wb_exc_valid = 1'b0;
        wb_exc_type  = EXC_NONE;
        wb_exc_pc    = '0;
        if (wb_a_valid && a_exc_q) begin
            wb_exc_valid = 1'b1;
            wb_exc_type  = a_etype_q;
            wb_exc_pc    = a_pc_q;
        end else if (wb_b_valid && b_exc_q) begin
            wb_exc_valid = 1'b1;
            wb_exc_type  = b_etype_q;
            wb_exc_pc    = b_pc_q;
        end
    end

    // Retired-instruction counter, wraps naturally modulo 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_q + {30'd0, n_commit};
        end
    end

    assign retired_count = retired_q;

    regfile_2w4r #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_REGS (RESET_REGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we_a    (wb_a_forwardable),
        .waddr_a (a_dest_q),
        .wdata_a (a_res_q),
        .we_b    (wb_b_forwardable),
        .waddr_b (b_dest_q),
        .wdata_b (b_res_q),
        .r1_addr (r1_addr),
        .r2_addr (r2_addr),
        .r3_addr (r3_addr),
        .r4_addr (r4_addr),
        .r1_data (r1_data),
        .r2_data (r2_data),
        .r3_data (r3_data),
        .r4_data (r4_data)
    );

endmodule
